// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - RV32I 5-stage hazard detection, operand forwarding and flush control
module hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       RdD,
  input  logic             UsesRs1D,
  input  logic             UsesRs2D,
  input  logic             RegWriteD,
  input  logic [1:0]       ResultSrcD,
  input  logic             PCSrcE,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             FlushE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [4:0] rs1_e;
  logic [4:0] rs2_e;
  logic [4:0] rd_e;
  logic       reg_write_e;
  logic       load_e;
  logic [4:0] rd_m;
  logic       reg_write_m;
  logic [4:0] rd_w;
  logic       reg_write_w;
  logic       lw_stall;

  // M beats W so the youngest producer wins; x0 is hardwired zero and never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic [4:0] rdm,
                                         input logic wm, input logic [4:0] rdw,
                                         input logic ww);
    logic [1:0] sel;
    sel = 2'b00;
    if (wm && (rdm != 5'd0) && (rdm == rs))
      sel = 2'b10;
    else if (ww && (rdw != 5'd0) && (rdw == rs))
      sel = 2'b01;
    return sel;
  endfunction

  always_comb begin
    lw_stall = load_e && (rd_e != 5'd0) &&
               ((UsesRs1D && (Rs1D == rd_e)) || (UsesRs2D && (Rs2D == rd_e)));
  end

  // A resolved branch makes the decode instruction wrong-path, so it overrides the stall.
  assign StallF    = lw_stall && !PCSrcE;
  assign StallD    = lw_stall && !PCSrcE;
  assign FlushD    = PCSrcE;
  assign FlushE    = lw_stall || PCSrcE;
  assign ForwardAE = fwd_sel(rs1_e, rd_m, reg_write_m, rd_w, reg_write_w);
  assign ForwardBE = fwd_sel(rs2_e, rd_m, reg_write_m, rd_w, reg_write_w);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs1_e       <= 5'd0;
      rs2_e       <= 5'd0;
      rd_e        <= 5'd0;
      reg_write_e <= 1'b0;
      load_e      <= 1'b0;
      rd_m        <= 5'd0;
      reg_write_m <= 1'b0;
      rd_w        <= 5'd0;
      reg_write_w <= 1'b0;
    end else begin
      if (FlushE) begin
        rs1_e       <= 5'd0;
        rs2_e       <= 5'd0;
        rd_e        <= 5'd0;
        reg_write_e <= 1'b0;
        load_e      <= 1'b0;
      end else begin
        rs1_e       <= Rs1D;
        rs2_e       <= Rs2D;
        rd_e        <= RdD;
        reg_write_e <= RegWriteD;
        load_e      <= (ResultSrcD == 2'b01);
      end
      rd_m        <= rd_e;
      reg_write_m <= reg_write_e;
      rd_w        <= rd_m;
      reg_write_w <= reg_write_m;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      if (StallD && (StallCount != CNT_MAX))
        StallCount <= StallCount + CNT_W'(1);
      if (FlushD && (FlushCount != CNT_MAX))
        FlushCount <= FlushCount + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed vector bench for hazard_ctrl
module tb_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [4:0]  rs1_d, rs2_d, rd_d;
  logic        uses_rs1_d, uses_rs2_d, reg_write_d, pc_src_e;
  logic [1:0]  result_src_d;
  logic        stall_f, stall_d, flush_d, flush_e;
  logic [1:0]  fwd_a, fwd_b;
  logic [15:0] stall_cnt, flush_cnt;

  logic [4:0]  s_rs1, s_rs2, s_rd;
  logic        s_u1, s_u2, s_rw, s_pc;
  logic [1:0]  s_rsrc;
  logic        s_stall_f, s_stall_d, s_flush_d, s_flush_e;
  logic [1:0]  s_fwd_a, s_fwd_b;
  logic [1:0]  s_stall_cnt, s_flush_cnt;

  hazard_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .Rs1D(rs1_d), .Rs2D(rs2_d), .RdD(rd_d),
    .UsesRs1D(uses_rs1_d), .UsesRs2D(uses_rs2_d), .RegWriteD(reg_write_d),
    .ResultSrcD(result_src_d), .PCSrcE(pc_src_e), .StallF(stall_f), .StallD(stall_d),
    .FlushD(flush_d), .FlushE(flush_e), .ForwardAE(fwd_a), .ForwardBE(fwd_b),
    .StallCount(stall_cnt), .FlushCount(flush_cnt)
  );

  hazard_ctrl #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .Rs1D(s_rs1), .Rs2D(s_rs2), .RdD(s_rd),
    .UsesRs1D(s_u1), .UsesRs2D(s_u2), .RegWriteD(s_rw),
    .ResultSrcD(s_rsrc), .PCSrcE(s_pc), .StallF(s_stall_f), .StallD(s_stall_d),
    .FlushD(s_flush_d), .FlushE(s_flush_e), .ForwardAE(s_fwd_a), .ForwardBE(s_fwd_b),
    .StallCount(s_stall_cnt), .FlushCount(s_flush_cnt)
  );

  typedef struct {
    logic [4:0] rs1, rs2, rd;
    logic       u1, u2, rw;
    logic [1:0] rsrc;
    logic       pc;
    logic       stall, fd, fe;
    logic [1:0] fa, fb;
    int         sc, fc;
  } vec_t;

  vec_t vecs [15];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic u1, input logic u2, input logic rw,
                       input logic [1:0] rsrc, input logic pc);
    rs1_d = rs1; rs2_d = rs2; rd_d = rd;
    uses_rs1_d = u1; uses_rs2_d = u2; reg_write_d = rw;
    result_src_d = rsrc; pc_src_e = pc;
  endtask

  task automatic sdrive(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic u1, input logic u2, input logic rw, input logic [1:0] rsrc);
    s_rs1 = rs1; s_rs2 = rs2; s_rd = rd;
    s_u1 = u1; s_u2 = u2; s_rw = rw; s_rsrc = rsrc; s_pc = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " stall_f"}, 32'(stall_f), 32'd0);
    check({tag, " stall_d"}, 32'(stall_d), 32'd0);
    check({tag, " flush_d"}, 32'(flush_d), 32'd0);
    check({tag, " flush_e"}, 32'(flush_e), 32'd0);
    check({tag, " fwd_a"},   32'(fwd_a),   32'd0);
    check({tag, " fwd_b"},   32'(fwd_b),   32'd0);
    check({tag, " stall_cnt"}, 32'(stall_cnt), 32'd0);
    check({tag, " flush_cnt"}, 32'(flush_cnt), 32'd0);
  endtask

  initial begin
    //            rs1 rs2 rd  u1 u2 rw rsrc   pc   stl fd fe fa     fb     sc fc
    vecs[0]  = '{5'd1, 5'd2, 5'd5, 1, 1, 1, 2'b00, 0,  0, 0, 0, 2'b00, 2'b00, 0, 0}; // add x5,x1,x2
    vecs[1]  = '{5'd5, 5'd1, 5'd6, 1, 1, 1, 2'b00, 0,  0, 0, 0, 2'b00, 2'b00, 0, 0}; // sub x6,x5,x1
    vecs[2]  = '{5'd5, 5'd0, 5'd7, 1, 1, 1, 2'b00, 0,  0, 0, 0, 2'b10, 2'b00, 0, 0}; // sub in E: M fwd
    vecs[3]  = '{5'd1, 5'd2, 5'd7, 1, 1, 1, 2'b00, 0,  0, 0, 0, 2'b01, 2'b00, 0, 0}; // x5 from W
    vecs[4]  = '{5'd0, 5'd7, 5'd0, 1, 1, 1, 2'b00, 0,  0, 0, 0, 2'b00, 2'b00, 0, 0};
    vecs[5]  = '{5'd0, 5'd0, 5'd0, 1, 1, 1, 2'b00, 0,  0, 0, 0, 2'b00, 2'b10, 0, 0}; // RdM=RdW=7
    vecs[6]  = '{5'd0, 5'd0, 5'd0, 1, 1, 1, 2'b00, 0,  0, 0, 0, 2'b00, 2'b00, 0, 0}; // x0 writer in M
    vecs[7]  = '{5'd1, 5'd0, 5'd3, 1, 0, 1, 2'b01, 0,  0, 0, 0, 2'b00, 2'b00, 0, 0}; // lw x3
    vecs[8]  = '{5'd3, 5'd2, 5'd4, 1, 1, 1, 2'b00, 0,  1, 0, 1, 2'b00, 2'b00, 0, 0}; // load-use
    vecs[9]  = '{5'd3, 5'd2, 5'd4, 1, 1, 1, 2'b00, 0,  0, 0, 0, 2'b00, 2'b00, 1, 0}; // held add
    vecs[10] = '{5'd0, 5'd0, 5'd0, 0, 0, 0, 2'b00, 0,  0, 0, 0, 2'b01, 2'b00, 1, 0}; // x3 from W
    vecs[11] = '{5'd0, 5'd0, 5'd0, 0, 0, 0, 2'b00, 1,  0, 1, 1, 2'b00, 2'b00, 1, 0}; // branch alone
    vecs[12] = '{5'd1, 5'd0, 5'd3, 1, 0, 1, 2'b01, 0,  0, 0, 0, 2'b00, 2'b00, 1, 1}; // lw x3
    vecs[13] = '{5'd3, 5'd2, 5'd4, 1, 1, 1, 2'b00, 1,  0, 1, 1, 2'b00, 2'b00, 1, 1}; // load-use + branch
    vecs[14] = '{5'd0, 5'd0, 5'd0, 0, 0, 0, 2'b00, 0,  0, 0, 0, 2'b00, 2'b00, 1, 2};

    rst_n = 1'b0;
    drive(5'd0, 5'd0, 5'd0, 0, 0, 0, 2'b00, 0);
    sdrive(5'd0, 5'd0, 5'd0, 0, 0, 0, 2'b00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      drive(vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].u1, vecs[i].u2, vecs[i].rw,
            vecs[i].rsrc, vecs[i].pc);
      @(negedge clk);
      check($sformatf("v%0d stall_f", i),   32'(stall_f),   32'(vecs[i].stall));
      check($sformatf("v%0d stall_d", i),   32'(stall_d),   32'(vecs[i].stall));
      check($sformatf("v%0d flush_d", i),   32'(flush_d),   32'(vecs[i].fd));
      check($sformatf("v%0d flush_e", i),   32'(flush_e),   32'(vecs[i].fe));
      check($sformatf("v%0d fwd_a", i),     32'(fwd_a),     32'(vecs[i].fa));
      check($sformatf("v%0d fwd_b", i),     32'(fwd_b),     32'(vecs[i].fb));
      check($sformatf("v%0d stall_cnt", i), 32'(stall_cnt), 32'(vecs[i].sc));
      check($sformatf("v%0d flush_cnt", i), 32'(flush_cnt), 32'(vecs[i].fc));
    end

    // addi x1 ; lw x3,0(x1) ; add x4,x3,x2 then reset while the stall is live
    @(posedge clk); #1 drive(5'd0, 5'd0, 5'd1, 1, 0, 1, 2'b00, 0);
    @(posedge clk); #1 drive(5'd1, 5'd0, 5'd3, 1, 0, 1, 2'b01, 0);
    @(posedge clk); #1 drive(5'd3, 5'd2, 5'd4, 1, 1, 1, 2'b00, 0);
    #2;
    check("pre_reset stall_d", 32'(stall_d), 32'd1);
    check("pre_reset fwd_a",   32'(fwd_a),   32'd2);
    check("pre_reset stall_cnt", 32'(stall_cnt), 32'd1);
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("post_release stall_d", 32'(stall_d), 32'd0);
    @(negedge clk);
    check_all_zero("post_release");

    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1 sdrive(5'd1, 5'd0, 5'd3, 1, 0, 1, 2'b01);
      @(posedge clk); #1 sdrive(5'd3, 5'd2, 5'd4, 1, 1, 1, 2'b00);
      @(negedge clk);
      check($sformatf("sat%0d stall_d", k),   32'(s_stall_d),   32'd1);
      check($sformatf("sat%0d stall_cnt", k), 32'(s_stall_cnt), (k < 3) ? 32'(k) : 32'd3);
    end
    @(posedge clk); #1 sdrive(5'd0, 5'd0, 5'd0, 0, 0, 0, 2'b00);
    @(negedge clk);
    check("sat_final stall_cnt", 32'(s_stall_cnt), 32'd3);
    check("sat_final flush_cnt", 32'(s_flush_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Hazard and forwarding controller for the 5-stage RV32I pipeline.
- Drives the hold and flush inputs of the fetch and decode-stage pipeline registers.
- Drives the clr input of the decode|execute register.
- Keeps a shadow pipeline of destination-register and control bits for the E, M and W stages, and produces operand-forwarding selects for execute.
- Provides saturating stall and flush event counters for performance measurement.

Parameters:
CNT_W, 16, width of the StallCount and FlushCount performance counters

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
Rs1D  input  5  rs1 field of the decode-stage instruction (InstrD[19:15])
Rs2D  input  5  rs2 field of the decode-stage instruction (InstrD[24:20])
RdD  input  5  rd field of the decode-stage instruction (InstrD[11:7])
UsesRs1D  input  1  decode-stage instruction reads rs1
UsesRs2D  input  1  decode-stage instruction reads rs2
RegWriteD  input  1  decode-stage instruction writes rd
ResultSrcD  input  2  decode-stage result select; 2'b01 = load from data memory
PCSrcE  input  1  taken branch, jal or jalr resolved in execute
StallF  output  1  1 = hold PC; feeds the active-low en of the fetch register
StallD  output  1  1 = hold the fetch|decode register; feeds its en
FlushD  output  1  clear the fetch|decode register
FlushE  output  1  clear the decode|execute register; feeds its clr
ForwardAE  output  2  SrcA select: 00 = register file, 10 = ALUResultM, 01 = ResultW
ForwardBE  output  2  WriteData/SrcB select, same encoding as ForwardAE
StallCount  output  CNT_W  number of cycles with StallD=1, saturating
FlushCount  output  CNT_W  number of cycles with FlushD=1, saturating

Behaviour:
- Reset:
  - rst_n low clears all shadow registers and both counters immediately, independent of clk.
  - With the shadow state cleared, every output is 0: no stall, no flush, forward select 00.
  - Reset asserted mid-operation discards all tracked hazards. No stall persists after rst_n returns high.
- Shadow pipeline, updated on each rising clk:
  - E stage holds Rs1E, Rs2E, RdE, RegWriteE and LoadE, where LoadE = (ResultSrcD == 2'b01).
  - If FlushE = 1, every E-stage field loads 0, which is a bubble.
  - Otherwise the E-stage fields load the corresponding D inputs.
  - RdM and RegWriteM load from E; RdW and RegWriteW load from M. These always advance and are never held.
- Forwarding (combinational from shadow registers):
  - ForwardAE = 10 if RegWriteM && RdM != 0 && RdM == Rs1E.
  - Else ForwardAE = 01 if RegWriteW && RdW != 0 && RdW == Rs1E.
  - Else ForwardAE = 00.
  - ForwardBE uses the same rules with Rs2E.
  - The M stage has priority over W when both match.
  - x0 is never forwarded.
- Load-use detection (combinational):
  - lwStall = LoadE && RdE != 0 && ((UsesRs1D && Rs1D == RdE) || (UsesRs2D && Rs2D == RdE)).
- Outputs:
  - StallF = StallD = lwStall && !PCSrcE.
  - FlushD = PCSrcE.
  - FlushE = lwStall || PCSrcE.
- Simultaneous load-use and taken branch:
  - The branch wins; the decode instruction is wrong-path.
  - No stall; both D and E are flushed.
- Latency:
  - Stall, flush and forward outputs are valid in the same cycle as their causes. No registered outputs other than the counters.
  - A load-use stall lasts exactly one cycle. The inserted bubble clears LoadE on the next edge.
- Register file:
  - Writes first, so a W-stage write is visible to a same-cycle decode read. No decode-stage forwarding is required.
- Counters:
  - Each counter increments by 1 on a rising clk when its event is 1.
  - Each counter holds at 2^CNT_W - 1 and never wraps.

Test Plan:
- Reset: rst_n=0 mid-stream with LoadE set by a prior load → all outputs 0 asynchronously. After release, StallCount=0 and FlushCount=0.
- EX→EX forward: add x5 in D, next cycle sub x6,x5,x1 in D → in sub's E cycle ForwardAE=10 and ForwardBE=00. One cycle later a consumer of x5 in E sees ForwardAE=01.
- Double hit: RdM=RdW=7 with both RegWrite=1 and Rs2E=7 → ForwardBE=10. Rd=0 writers with Rs1E=0 → ForwardAE=00.
- Load-use: lw x3 (ResultSrcD=01) followed by add x4,x3,x2 → next cycle StallF=StallD=FlushE=1 for exactly 1 cycle. Then ForwardAE=01 and StallCount=1.
- Branch: PCSrcE=1 alone → FlushD=FlushE=1, StallD=0, FlushCount increments by 1. PCSrcE=1 together with a load-use condition → StallF=StallD=0, FlushD=FlushE=1.
- Saturation: CNT_W=2 with 5 consecutive load-use stalls → StallCount stops at 3.
